// File: rtl/apb_fabric_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_fabric_if
// Description : APB3 bus bundle between the fabric (master) and NUM_SLAVES
//               peripherals; PRDATA holds slave i at [i*DATA_W +: DATA_W].
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_fabric_if #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32
);
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [31:0]                  PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_fabric.sv
`default_nettype none
// ============================================================================
// Module      : apb_fabric
// Description : Core data-port to multi-slave APB3 front-end with window
//               decode, per-slave PSEL, response mux, stall and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_fabric #(
    parameter int          NUM_SLAVES = 4,
    parameter int          DATA_W     = 32,
    parameter logic [15:0] BASE_HI    = 16'h4000,
    parameter int          TIMEOUT    = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [31:0]       rv_addr,
    input  wire logic [DATA_W-1:0] rv_wdata,
    input  wire logic              rv_mem_write,
    input  wire logic              rv_mem_read,
    output logic [DATA_W-1:0]      rv_rdata,
    output logic                   cpu_stall,
    output logic                   bus_error,
    output logic [31:0]            err_addr,
    apb_fabric_if.master           apb
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_SETUP   = 2'd1;
    localparam logic [1:0]  c_ACCESS  = 2'd2;
    localparam logic [1:0]  c_DONE    = 2'd3;
    localparam logic [7:0]  c_NUM_SLV = 8'(NUM_SLAVES);
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]             r_state;
    logic [7:0]             r_slot;
    logic                   r_pwrite;
    logic [31:0]            r_paddr;
    logic [DATA_W-1:0]      r_pwdata;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_err;
    logic [31:0]            r_err_addr;
    logic [15:0]            r_cnt;

    logic                   w_hit;
    logic                   w_mapped;
    logic                   w_bus_phase;
    logic [NUM_SLAVES-1:0]  w_onehot;
    logic                   w_sel_ready;
    logic                   w_sel_err;
    logic [DATA_W-1:0]      w_sel_rdata;

    assign w_hit    = (rv_mem_read | rv_mem_write) && (rv_addr[31:16] == BASE_HI);
    assign w_mapped = rv_addr[15:8] < c_NUM_SLV;

    // Only the latched slot's response lines are ever looked at.
    always_comb begin
        w_onehot    = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_slot == 8'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_ready = apb.PREADY[i];
                w_sel_err   = apb.PSLVERR[i];
                w_sel_rdata = apb.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_slot     <= '0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hit) begin
                        r_paddr  <= rv_addr;
                        r_pwdata <= rv_wdata;
                        r_pwrite <= rv_mem_write;
                        r_slot   <= rv_addr[15:8];
                        if (w_mapped) begin
                            r_state <= c_SETUP;
                            r_err   <= 1'b0;
                        end else begin
                            r_state    <= c_DONE;
                            r_err      <= 1'b1;
                            r_err_addr <= rv_addr;
                        end
                    end
                end
                c_SETUP: begin
                    r_state <= c_ACCESS;
                    r_cnt   <= '0;
                end
                c_ACCESS: begin
                    if (w_sel_ready) begin
                        r_state <= c_DONE;
                        r_err   <= w_sel_err;
                        if (!r_pwrite) begin
                            r_rdata <= w_sel_err ? '0 : w_sel_rdata;
                        end
                        if (w_sel_err) begin
                            r_err_addr <= r_paddr;
                        end
                    end else begin
                        // Counter stops at TIMEOUT because the abort leaves ACCESS.
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == c_TO_LAST) begin
                            r_state    <= c_DONE;
                            r_err      <= 1'b1;
                            r_err_addr <= r_paddr;
                            if (!r_pwrite) begin
                                r_rdata <= '0;
                            end
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_bus_phase = (r_state == c_SETUP) || (r_state == c_ACCESS);

    assign apb.PSEL    = w_bus_phase ? w_onehot : '0;
    assign apb.PENABLE = (r_state == c_ACCESS);
    assign apb.PWRITE  = r_pwrite;
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;

    assign rv_rdata  = r_rdata;
    assign err_addr  = r_err_addr;
    assign bus_error = (r_state == c_DONE) && r_err;
    assign cpu_stall = ((r_state == c_IDLE) && w_hit) || w_bus_phase;

endmodule
`default_nettype wire

// File: tb/tb_apb_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_fabric
// Description : Directed self-checking bench for apb_fabric (4 slaves,
//               TIMEOUT=8) with a simple per-slave responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_fabric;

    localparam int c_NS   = 4;
    localparam int c_DW   = 32;
    localparam int c_TO   = 8;
    localparam int c_MAXC = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rv_addr = '0;
    logic [31:0] rv_wdata = '0;
    logic        rv_mem_write = 1'b0;
    logic        rv_mem_read = 1'b0;
    logic [31:0] rv_rdata;
    logic        cpu_stall;
    logic        bus_error;
    logic [31:0] err_addr;

    apb_fabric_if #(.NUM_SLAVES(c_NS), .DATA_W(c_DW)) bus ();

    apb_fabric #(
        .NUM_SLAVES (c_NS),
        .DATA_W     (c_DW),
        .BASE_HI    (16'h4000),
        .TIMEOUT    (c_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rv_addr      (rv_addr),
        .rv_wdata     (rv_wdata),
        .rv_mem_write (rv_mem_write),
        .rv_mem_read  (rv_mem_read),
        .rv_rdata     (rv_rdata),
        .cpu_stall    (cpu_stall),
        .bus_error    (bus_error),
        .err_addr     (err_addr),
        .apb          (bus.master)
    );

    always #5 clk = ~clk;

    // Responder: target slave becomes ready after wait_cfg ACCESS cycles.
    // Slave 3 (never addressed) always shows ready+error to expose bad muxing.
    int   tgt = 0;
    int   wait_cfg = 0;
    logic err_cfg = 1'b0;
    logic hang_cfg = 1'b0;
    int   acc_cnt = 0;

    always @(posedge clk) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

    assign bus.PRDATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

    always_comb begin
        bus.PREADY  = 4'b1000;
        bus.PSLVERR = 4'b1000;
        if (!hang_cfg && (acc_cnt >= wait_cfg)) bus.PREADY[tgt] = 1'b1;
        if (err_cfg) bus.PSLVERR[tgt] = 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last transfer
    int          stall_cnt;
    int          pen_cnt;
    logic [3:0]  psel_or;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_write;
    logic        unstable;
    logic        d_err;
    logic [31:0] d_rdata;
    logic [31:0] d_eaddr;
    logic [3:0]  d_psel;
    logic        d_pen;

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        int cyc;
        @(posedge clk); #1;
        rv_addr = a; rv_wdata = d; rv_mem_read = r; rv_mem_write = w;
        stall_cnt = 0; pen_cnt = 0; psel_or = '0; unstable = 1'b0;
        s_addr = '0; s_wdata = '0; s_write = 1'b0;
        cyc = 0;
        #1;
        while (cpu_stall && cyc < c_MAXC) begin
            stall_cnt++;
            psel_or = psel_or | bus.PSEL;
            if (bus.PENABLE) begin
                pen_cnt++;
                if (bus.PADDR !== s_addr || bus.PWDATA !== s_wdata || bus.PWRITE !== s_write)
                    unstable = 1'b1;
            end else if (bus.PSEL != 4'b0) begin
                s_addr = bus.PADDR; s_wdata = bus.PWDATA; s_write = bus.PWRITE;
            end
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= c_MAXC) check_val("xfer_bound", 64'(cyc), 64'(c_MAXC - 1));
        d_err = bus_error; d_rdata = rv_rdata; d_eaddr = err_addr;
        d_psel = bus.PSEL; d_pen = bus.PENABLE;
        @(posedge clk); #1;
        rv_mem_read = 1'b0; rv_mem_write = 1'b0;
        #1;
        check_val("err_pulse_len", 64'(bus_error), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_psel",    64'(bus.PSEL),    64'd0);
        check_val("rst_penable", 64'(bus.PENABLE), 64'd0);
        check_val("rst_pwrite",  64'(bus.PWRITE),  64'd0);
        check_val("rst_paddr",   64'(bus.PADDR),   64'd0);
        check_val("rst_pwdata",  64'(bus.PWDATA),  64'd0);
        check_val("rst_rdata",   64'(rv_rdata),    64'd0);
        check_val("rst_berr",    64'(bus_error),   64'd0);
        check_val("rst_eaddr",   64'(err_addr),    64'd0);
        check_val("rst_stall",   64'(cpu_stall),   64'd0);
        rst = 1'b0;

        // Zero-wait read of slot 0
        tgt = 0; wait_cfg = 0; err_cfg = 1'b0; hang_cfg = 1'b0;
        xfer(32'h4000_0004, 32'h0, 1'b1, 1'b0);
        check_val("rd0_stall", 64'(stall_cnt), 64'd3);
        check_val("rd0_psel",  64'(psel_or),   64'h1);
        check_val("rd0_pen",   64'(pen_cnt),   64'd1);
        check_val("rd0_data",  64'(d_rdata),   64'h1234_5678);
        check_val("rd0_err",   64'(d_err),     64'd0);
        check_val("rd0_done_psel", 64'(d_psel), 64'd0);

        // Write to slot 2 with three wait states
        tgt = 2; wait_cfg = 3;
        xfer(32'h4000_0208, 32'hA5A5_A5A5, 1'b0, 1'b1);
        check_val("wr2_stall",  64'(stall_cnt), 64'd6);
        check_val("wr2_psel",   64'(psel_or),   64'h4);
        check_val("wr2_pwrite", 64'(s_write),   64'd1);
        check_val("wr2_pwdata", 64'(s_wdata),   64'hA5A5_A5A5);
        check_val("wr2_paddr",  64'(s_addr),    64'h4000_0208);
        check_val("wr2_stable", 64'(unstable),  64'd0);
        check_val("wr2_err",    64'(d_err),     64'd0);
        check_val("wr2_rdhold", 64'(d_rdata),   64'h1234_5678);

        // Read and write together is a write
        tgt = 0; wait_cfg = 0;
        xfer(32'h4000_0010, 32'hCAFE_F00D, 1'b1, 1'b1);
        check_val("rw_pwrite", 64'(s_write), 64'd1);
        check_val("rw_pwdata", 64'(s_wdata), 64'hCAFE_F00D);
        check_val("rw_rdhold", 64'(d_rdata), 64'h1234_5678);

        // Slave error on slot 1 read
        tgt = 1; wait_cfg = 0; err_cfg = 1'b1;
        xfer(32'h4000_0104, 32'h0, 1'b1, 1'b0);
        check_val("slverr_data",  64'(d_rdata), 64'd0);
        check_val("slverr_berr",  64'(d_err),   64'd1);
        check_val("slverr_eaddr", 64'(d_eaddr), 64'h4000_0104);
        check_val("slverr_stall", 64'(stall_cnt), 64'd3);

        // Slot 2 read with one wait state
        tgt = 2; wait_cfg = 1; err_cfg = 1'b0;
        xfer(32'h4000_0200, 32'h0, 1'b1, 1'b0);
        check_val("rd2_stall", 64'(stall_cnt), 64'd4);
        check_val("rd2_data",  64'(d_rdata),   64'h2222_2222);
        check_val("rd2_err",   64'(d_err),     64'd0);

        // Timeout on slot 1
        tgt = 1; wait_cfg = 0; hang_cfg = 1'b1;
        xfer(32'h4000_0100, 32'h0, 1'b1, 1'b0);
        check_val("to_access", 64'(pen_cnt),   64'(c_TO));
        check_val("to_stall",  64'(stall_cnt), 64'(c_TO + 2));
        check_val("to_berr",   64'(d_err),     64'd1);
        check_val("to_eaddr",  64'(d_eaddr),   64'h4000_0100);
        check_val("to_data",   64'(d_rdata),   64'd0);
        check_val("to_psel",   64'(d_psel),    64'd0);
        check_val("to_pen",    64'(d_pen),     64'd0);
        hang_cfg = 1'b0;

        // Unmapped slot
        xfer(32'h4000_0700, 32'h0, 1'b1, 1'b0);
        check_val("unmap_stall", 64'(stall_cnt), 64'd1);
        check_val("unmap_psel",  64'(psel_or),   64'd0);
        check_val("unmap_berr",  64'(d_err),     64'd1);
        check_val("unmap_eaddr", 64'(d_eaddr),   64'h4000_0700);

        // Outside the peripheral window
        xfer(32'h1000_0000, 32'h0, 1'b1, 1'b0);
        check_val("nowin_stall", 64'(stall_cnt), 64'd0);
        check_val("nowin_psel",  64'(d_psel),    64'd0);
        check_val("nowin_berr",  64'(d_err),     64'd0);
        check_val("nowin_eaddr", 64'(d_eaddr),   64'h4000_0700);

        // Reset while in ACCESS
        tgt = 0; wait_cfg = 0;
        xfer(32'h4000_0000, 32'h0, 1'b1, 1'b0);
        check_val("pre_rst_data", 64'(d_rdata), 64'h1234_5678);
        tgt = 1; hang_cfg = 1'b1;
        @(posedge clk); #1;
        rv_addr = 32'h4000_0100; rv_mem_read = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.PENABLE && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check_val("reach_access", 64'(bus.PENABLE), 64'd1);
        end
        rst = 1'b1; rv_mem_read = 1'b0;
        @(posedge clk); #1;
        check_val("arst_psel",  64'(bus.PSEL),    64'd0);
        check_val("arst_pen",   64'(bus.PENABLE), 64'd0);
        check_val("arst_stall", 64'(cpu_stall),   64'd0);
        check_val("arst_data",  64'(rv_rdata),    64'd0);
        check_val("arst_eaddr", 64'(err_addr),    64'd0);
        rst = 1'b0; hang_cfg = 1'b0; tgt = 0;
        xfer(32'h4000_0004, 32'h0, 1'b1, 1'b0);
        check_val("post_rst_stall", 64'(stall_cnt), 64'd3);
        check_val("post_rst_data",  64'(d_rdata),   64'h1234_5678);
        check_val("post_rst_err",   64'(d_err),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
